// File: rtl/two_way_line_array_pkg.sv
// rtl/two_way_line_array_pkg.sv - shared L1 cache geometry and address slicing
package two_way_line_array_pkg;

    localparam int CACHE_LINES      = 32;
    localparam int CACHE_INDEX_BITS = 5;
    localparam int CACHE_DATA_BITS  = 128;
    localparam int CACHE_TAG_BITS   = 23;
    localparam int CACHE_WRITE_BITS = 16;

    // Address field boundaries: tag [31:9], index [8:4], word offset [3:2].
    localparam int CACHE_TAG_MSB     = 31;
    localparam int CACHE_TAG_LSB     = 9;
    localparam int CACHE_INDEX_MSB   = 8;
    localparam int CACHE_INDEX_LSB   = 4;
    localparam int CACHE_OFFEST_MSB  = 3;
    localparam int CACHE_OFFEST_LSB  = 2;

    typedef logic [CACHE_TAG_BITS-1:0]   cache_tag_t;
    typedef logic [CACHE_INDEX_BITS-1:0] cache_index_t;
    typedef logic [1:0]                  cache_offset_t;

    function automatic cache_tag_t cache_tag(input logic [31:0] addr);
        return addr[CACHE_TAG_MSB:CACHE_TAG_LSB];
    endfunction

    function automatic cache_index_t cache_index(input logic [31:0] addr);
        return addr[CACHE_INDEX_MSB:CACHE_INDEX_LSB];
    endfunction

    function automatic cache_offset_t cache_offest(input logic [31:0] addr);
        return addr[CACHE_OFFEST_MSB:CACHE_OFFEST_LSB];
    endfunction

endpackage

// File: rtl/two_way_line_array_if.sv
// rtl/two_way_line_array_if.sv - shared-index access bus for the two-way line array
interface two_way_line_array_if #(
    parameter int AW   = 5,
    parameter int DW   = 128,
    parameter int WE_W = 16
);
    logic            CS;
    logic            OE;
    logic [AW-1:0]   A;
    logic [WE_W-1:0] WEB1;
    logic [WE_W-1:0] WEB2;
    logic [DW-1:0]   DI;
    logic [DW-1:0]   DO1;
    logic [DW-1:0]   DO2;

    modport master (
        output CS, OE, A, WEB1, WEB2, DI,
        input  DO1, DO2
    );

    modport slave (
        input  CS, OE, A, WEB1, WEB2, DI,
        output DO1, DO2
    );
endinterface

// File: rtl/two_way_line_array_sram_way.sv
// rtl/two_way_line_array_sram_way.sv - one lane-masked synchronous RAM way with output register
module sram_way #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 128,
    parameter int WE_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cs_i,
    input  logic            oe_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [WE_W-1:0] we_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);
    localparam int LW = DW / WE_W;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Contents are deliberately never reset; reset only suppresses writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i && cs_i) begin
            for (int k = 0; k < WE_W; k++) begin
                if (we_i[k]) begin
                    mem_q[addr_i][k*LW +: LW] <= wdata_i[k*LW +: LW];
                end
            end
        end
    end

    // Non-blocking read of the same entry yields pre-write data on a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (cs_i && oe_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/two_way_line_array_wrappers.sv
// rtl/two_way_line_array_wrappers.sv - data-array and tag-array configurations of the line array
module data_array_wrapper
    import two_way_line_array_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        CS,
    input  logic                        OE,
    input  logic [CACHE_INDEX_BITS-1:0] A,
    input  logic [CACHE_WRITE_BITS-1:0] WEB1,
    input  logic [CACHE_WRITE_BITS-1:0] WEB2,
    input  logic [CACHE_DATA_BITS-1:0]  DI,
    output logic [CACHE_DATA_BITS-1:0]  DO1,
    output logic [CACHE_DATA_BITS-1:0]  DO2
);
    two_way_line_array_if #(
        .AW   (CACHE_INDEX_BITS),
        .DW   (CACHE_DATA_BITS),
        .WE_W (CACHE_WRITE_BITS)
    ) data_bus ();

    assign data_bus.CS   = CS;
    assign data_bus.OE   = OE;
    assign data_bus.A    = A;
    assign data_bus.WEB1 = WEB1;
    assign data_bus.WEB2 = WEB2;
    assign data_bus.DI   = DI;
    assign DO1 = data_bus.DO1;
    assign DO2 = data_bus.DO2;

    two_way_line_array #(
        .DEPTH (CACHE_LINES),
        .AW    (CACHE_INDEX_BITS),
        .DW    (CACHE_DATA_BITS),
        .WE_W  (CACHE_WRITE_BITS)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (data_bus)
    );
endmodule

module tag_array_wrapper
    import two_way_line_array_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        CS,
    input  logic                        OE,
    input  logic [CACHE_INDEX_BITS-1:0] A,
    input  logic [0:0]                  WEB1,
    input  logic [0:0]                  WEB2,
    input  logic [CACHE_TAG_BITS-1:0]   DI,
    output logic [CACHE_TAG_BITS-1:0]   DO1,
    output logic [CACHE_TAG_BITS-1:0]   DO2
);
    // A tag is written as a whole, so one lane spans the full entry.
    two_way_line_array_if #(
        .AW   (CACHE_INDEX_BITS),
        .DW   (CACHE_TAG_BITS),
        .WE_W (1)
    ) tag_bus ();

    assign tag_bus.CS   = CS;
    assign tag_bus.OE   = OE;
    assign tag_bus.A    = A;
    assign tag_bus.WEB1 = WEB1;
    assign tag_bus.WEB2 = WEB2;
    assign tag_bus.DI   = DI;
    assign DO1 = tag_bus.DO1;
    assign DO2 = tag_bus.DO2;

    two_way_line_array #(
        .DEPTH (CACHE_LINES),
        .AW    (CACHE_INDEX_BITS),
        .DW    (CACHE_TAG_BITS),
        .WE_W  (1)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (tag_bus)
    );
endmodule

// File: rtl/two_way_line_array.sv
// rtl/two_way_line_array.sv - two independent ways sharing index, write data and read strobe
module two_way_line_array
    import two_way_line_array_pkg::*;
#(
    parameter int DEPTH = CACHE_LINES,
    parameter int AW    = CACHE_INDEX_BITS,
    parameter int DW    = CACHE_DATA_BITS,
    parameter int WE_W  = CACHE_WRITE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    two_way_line_array_if.slave  bus
);
    logic [DW-1:0] way1_rdata;
    logic [DW-1:0] way2_rdata;

    sram_way #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .WE_W  (WE_W)
    ) u_way1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cs_i    (bus.CS),
        .oe_i    (bus.OE),
        .addr_i  (bus.A),
        .we_i    (bus.WEB1),
        .wdata_i (bus.DI),
        .rdata_o (way1_rdata)
    );

    sram_way #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .WE_W  (WE_W)
    ) u_way2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cs_i    (bus.CS),
        .oe_i    (bus.OE),
        .addr_i  (bus.A),
        .we_i    (bus.WEB2),
        .wdata_i (bus.DI),
        .rdata_o (way2_rdata)
    );

    assign bus.DO1 = way1_rdata;
    assign bus.DO2 = way2_rdata;

endmodule

// File: tb/tb_two_way_line_array.sv
// tb/tb_two_way_line_array.sv - directed self-checking bench for data and tag configurations
module tb_two_way_line_array;
    import two_way_line_array_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    two_way_line_array_if #(.AW(5), .DW(128), .WE_W(16)) bus ();

    two_way_line_array #(.DEPTH(32), .AW(5), .DW(128), .WE_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    logic        t_cs, t_oe;
    logic [4:0]  t_a;
    logic [0:0]  t_we1, t_we2;
    logic [22:0] t_di, t_do1, t_do2;

    tag_array_wrapper u_tag (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .CS    (t_cs),
        .OE    (t_oe),
        .A     (t_a),
        .WEB1  (t_we1),
        .WEB2  (t_we2),
        .DI    (t_di),
        .DO1   (t_do1),
        .DO2   (t_do2)
    );

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] PAT_OLD = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
    localparam logic [127:0] PAT_D0  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] ONES    = {128{1'b1}};
    localparam logic [127:0] V1      = 128'hA1A1_A1A1_B2B2_B2B2_C3C3_C3C3_D4D4_D4D4;
    localparam logic [127:0] V2      = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] V3      = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    localparam logic [127:0] V4      = 128'h1234_0000_0000_0000_0000_0000_0000_5678;
    localparam logic [127:0] XVAL    = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic cs, input logic oe, input logic [4:0] a,
                         input logic [15:0] w1, input logic [15:0] w2, input logic [127:0] di);
        bus.CS = cs; bus.OE = oe; bus.A = a; bus.WEB1 = w1; bus.WEB2 = w2; bus.DI = di;
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 16'h0, 16'h0, '0);
        t_cs = 1'b0; t_oe = 1'b0; t_a = '0; t_we1 = '0; t_we2 = '0; t_di = '0;

        step();
        chk("reset_do1", bus.DO1, '0);
        chk("reset_do2", bus.DO2, '0);
        chk("reset_tag_do1", {105'd0, t_do1}, '0);
        rst_i = 1'b0;

        // Full write and readback, way 2 prefilled with a known old value
        drive(1'b1, 1'b0, 5'd3, 16'h0000, 16'hFFFF, PAT_OLD); step();
        drive(1'b1, 1'b0, 5'd3, 16'hFFFF, 16'h0000, PAT_D0);  step();
        drive(1'b1, 1'b1, 5'd3, 16'h0000, 16'h0000, '0);      step();
        chk("full_wr_do1", bus.DO1, PAT_D0);
        chk("full_wr_do2_old", bus.DO2, PAT_OLD);

        // Lane mask on way 2 entry 5
        drive(1'b1, 1'b0, 5'd5, 16'h0000, 16'hFFFF, ONES); step();
        drive(1'b1, 1'b0, 5'd5, 16'h0000, 16'h0F00, 128'h0000_0000_AAAA_AAAA_0000_0000_0000_0000); step();
        drive(1'b1, 1'b1, 5'd5, 16'h0000, 16'h0000, '0); step();
        chk("lane_mask_do2", bus.DO2, 128'hFFFF_FFFF_AAAA_AAAA_FFFF_FFFF_FFFF_FFFF);

        // Word 0 lives in the MSB lanes
        drive(1'b1, 1'b0, 5'd6, 16'hFFFF, 16'h0000, '0);   step();
        drive(1'b1, 1'b0, 5'd6, 16'hF000, 16'h0000, ONES); step();
        drive(1'b1, 1'b1, 5'd6, 16'h0000, 16'h0000, '0);   step();
        chk("word0_msb_do1", bus.DO1, 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000);

        // Hold across address change, write, and CS low
        drive(1'b1, 1'b0, 5'd7, 16'hFFFF, 16'hFFFF, V1); step();
        drive(1'b1, 1'b0, 5'd9, 16'hFFFF, 16'hFFFF, V2); step();
        drive(1'b1, 1'b0, 5'd7, 16'h0000, 16'hFFFF, V2); step();
        drive(1'b1, 1'b1, 5'd7, 16'h0000, 16'h0000, '0); step();
        chk("hold_load_do1", bus.DO1, V1);
        chk("hold_load_do2", bus.DO2, V2);
        drive(1'b1, 1'b0, 5'd9, 16'h0000, 16'h0000, '0); step();
        chk("hold_addr_do1", bus.DO1, V1);
        drive(1'b1, 1'b0, 5'd7, 16'hFFFF, 16'hFFFF, V3); step();
        chk("hold_write_do1", bus.DO1, V1);
        chk("hold_write_do2", bus.DO2, V2);
        drive(1'b0, 1'b1, 5'd7, 16'hFFFF, 16'hFFFF, V4); step();
        chk("hold_cs_low_do1", bus.DO1, V1);
        drive(1'b1, 1'b1, 5'd7, 16'h0000, 16'h0000, '0); step();
        chk("cs_low_no_wr_do1", bus.DO1, V3);
        chk("cs_low_no_wr_do2", bus.DO2, V3);

        // Read/write collision returns pre-write data
        drive(1'b1, 1'b0, 5'd2, 16'hFFFF, 16'hFFFF, PAT_OLD); step();
        drive(1'b1, 1'b1, 5'd2, 16'hFFFF, 16'h0000, XVAL);    step();
        chk("collision_old_do1", bus.DO1, PAT_OLD);
        drive(1'b1, 1'b1, 5'd2, 16'h0000, 16'h0000, '0); step();
        chk("collision_new_do1", bus.DO1, XVAL);
        chk("collision_do2", bus.DO2, PAT_OLD);

        // Reset clears outputs, suppresses the write, keeps contents
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 5'd2, 16'hFFFF, 16'hFFFF, V4); step();
        chk("midreset_do1", bus.DO1, '0);
        chk("midreset_do2", bus.DO2, '0);
        rst_i = 1'b0;
        drive(1'b1, 1'b1, 5'd2, 16'h0000, 16'h0000, '0); step();
        chk("post_reset_do1", bus.DO1, XVAL);
        chk("post_reset_do2", bus.DO2, PAT_OLD);

        // Index boundaries 0 and 31
        drive(1'b1, 1'b0, 5'd0,  16'hFFFF, 16'h0000, V1); step();
        drive(1'b1, 1'b0, 5'd31, 16'hFFFF, 16'h0000, V2); step();
        drive(1'b1, 1'b1, 5'd0,  16'h0000, 16'h0000, '0); step();
        chk("index0_do1", bus.DO1, V1);
        drive(1'b1, 1'b1, 5'd31, 16'h0000, 16'h0000, '0); step();
        chk("index31_do1", bus.DO1, V2);

        // Tag configuration: both ways at entry 31, entry 30 untouched
        t_cs = 1'b1; t_oe = 1'b0; t_a = 5'd30; t_we1 = 1'b1; t_we2 = 1'b1; t_di = 23'h7ABCD; step();
        t_a = 5'd31; t_di = 23'h12345; step();
        t_we1 = 1'b0; t_we2 = 1'b0; t_oe = 1'b1; t_di = '0; step();
        chk("tag31_do1", {105'd0, t_do1}, {105'd0, 23'h12345});
        chk("tag31_do2", {105'd0, t_do2}, {105'd0, 23'h12345});
        t_a = 5'd30; step();
        chk("tag30_do1", {105'd0, t_do1}, {105'd0, 23'h7ABCD});
        chk("tag30_do2", {105'd0, t_do2}, {105'd0, 23'h7ABCD});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/two_way_line_array.md
# two_way_line_array

Synchronous-read storage for one 2-way set-associative L1 cache: two independent ways share one index, one write-data bus and one read strobe. Each way has its own lane write mask and output register. The same block serves as the instruction-cache data array (128-bit lines, 16 byte lanes) and the tag array (23-bit tags, 1 lane). The cache controller keeps the valid and replacement bits; this block stores only contents.

## Interface
Parameters:
- DEPTH, 32: sets per way (CACHE_LINES).
- AW, 5: index width, clog2(DEPTH) (CACHE_INDEX_BITS).
- DW, 128: entry width (data: CACHE_DATA_BITS=128; tag: CACHE_TAG_BITS=23).
- WE_W, 16: write lanes per entry (data: CACHE_WRITE_BITS=16; tag: 1). DW must be a multiple of WE_W.

Ports:
- clk_i  in  1  clock. One clock; all activity is on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- CS  in  1  chip select. When low, no read and no write occur.
- OE  in  1  read strobe, sampled with A.
- A  in  AW  set index, shared by read and write.
- WEB1  in  WE_W  way-1 lane write enables, active-high despite the name.
- WEB2  in  WE_W  way-2 lane write enables, active-high.
- DI  in  DW  write data, shared by both ways.
- DO1  out  DW  registered way-1 read data.
- DO2  out  DW  registered way-2 read data.

## Operation
- Lane mapping: lane bit k covers DI[(k+1)*DW/WE_W-1 : k*DW/WE_W]. The MSB enable covers the MSB slice.
- Data-array use: mask 16'hF000 writes word 0, which sits at DI[127:96]. Word 3 sits at [31:0].
- Write: on an edge with CS=1, each way writes the enabled lanes of DI into entry A. Disabled lanes keep their old contents. The two ways write independently and may both write in the same cycle.
- Read: on an edge with CS=1 and OE=1, DO1 and DO2 load ways 1 and 2 of entry A.
- Hold: when OE=0 or CS=0, DO1 and DO2 hold their last value. This holds even if A changes or a write occurs. The controller depends on this: it loads the outputs in one cycle and evaluates the hit in later cycles with OE low.
- Read and write to the same entry in the same cycle: DO returns the old (pre-write) contents. The write takes effect for later reads.
- Array contents are not cleared by reset. Unwritten entries are don't-care; the controller's valid bits mask them.

## Timing
- Read latency is 1 cycle. With OE=1 and A=i at edge N, DO reflects entry i from edge N onward.
- Write latency is 1 cycle. Data written at edge N is readable by a read issued at edge N+1, with DO updating at N+1.
- Reset: while rst_i=1 at an edge, DO1 and DO2 are cleared to 0. Reset has priority over reads. Writes are suppressed during reset.
- Reset mid-operation leaves the array contents unchanged.
- Every index 0..DEPTH-1 is valid. There is no wrap-around and no out-of-range case.
- There is no handshake and no stall: the block accepts an operation every cycle.

## Structure
- Shared cache package holds:
  - CACHE_LINES=32, CACHE_INDEX_BITS=5, CACHE_DATA_BITS=128, CACHE_TAG_BITS=23, CACHE_WRITE_BITS=16.
  - Address slices: CACHE_TAG=[31:9], CACHE_INDEX=[8:4], CACHE_OFFEST=[3:2].
- One sub-module, sram_way: a single-way DEPTH×DW lane-masked synchronous RAM with its own output register. Instantiate it twice.
- data_array_wrapper instantiates this block with DW=128, WE_W=16.
- tag_array_wrapper instantiates this block with DW=23, WE_W=1.

## Test plan
- Full write and readback (data config): WEB1=16'hFFFF, A=3, DI=128'h0123…CDEF. Next cycle OE=1, A=3 → DO1=DI one cycle later; DO2 shows old contents.
- Lane mask: prefill entry 5 way 2 with all-ones. Write WEB2=16'h0F00, DI=128'h0000_0000_AAAA_AAAA_0…0. Read entry 5 → DO2=128'hFFFF_FFFF_AAAA_AAAA_FFFF_FFFF_FFFF_FFFF.
- Hold: read A=7 with OE=1, then OE=0 with A=9 and a write to entry 7 → DO1 and DO2 keep the old entry-7 values until the next OE=1.
- Tag config, both ways: write 23'h12345 with WEB1=1 and WEB2=1 at A=31 → a read of A=31 gives DO1=DO2=23'h12345. Entry 30 is unaffected.
- Collision: OE=1 and WEB1=all-ones with DI=X at A=2 in the same cycle → DO1=old value. The next read returns X.
- Reset: after DO is loaded nonzero, assert rst_i for 1 cycle → DO1=DO2=0. A following read returns the pre-reset array contents.
